// File: rtl/sched_crossbar_reg_pkg.sv
// Shared definitions for the scheduled crossbar.
//
// Contents:
//   sel_width          egress-index width for a given port count
//   sched_entry_t      per-ingress schedule entry {en, sel} at the default port count
//   resolve_t          cleaned enable mask plus conflict flag
//   resolve_conflicts  applies lowest-index-wins ownership to an incoming schedule
//
// The resolver works on fixed maximum-size vectors so that one package function
// serves every PORT_CNT. Callers zero-pad their schedule and pass the real port count.
package sched_crossbar_pkg;

  localparam int PORT_CNT_DEF = 4;
  localparam int MAX_PORTS    = 64;
  localparam int MAX_SEL_W    = 6;

  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int SEL_W_DEF = sel_width(PORT_CNT_DEF);

  typedef struct packed {
    logic                 en;
    logic [SEL_W_DEF-1:0] sel;
  } sched_entry_t;

  typedef struct packed {
    logic [MAX_PORTS-1:0] en;
    logic                 conflict;
  } resolve_t;

  // Walk the ingresses in ascending order. The first enabled ingress to claim an
  // egress owns it. Any later claimant loses its enable bit and flags a conflict.
  function automatic resolve_t resolve_conflicts(
    input logic [MAX_PORTS-1:0]                en,
    input logic [MAX_PORTS-1:0][MAX_SEL_W-1:0] sel,
    input int                                  n
  );
    resolve_t             r;
    logic [MAX_PORTS-1:0] claimed;
    r.en       = en;
    r.conflict = 1'b0;
    claimed    = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (i < n && en[i]) begin
        if (claimed[sel[i]]) begin
          r.en[i]    = 1'b0;
          r.conflict = 1'b1;
        end else begin
          claimed[sel[i]] = 1'b1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sched_crossbar_reg_if.sv
// Bus bundle for sched_crossbar_reg.
//
// Signals:
//   sched_sel/sched_en/sched_load  schedule from the scheduler
//   in_valid/in_data/in_ready      ingress side (VOQ read)
//   out_valid/out_data/out_ready   egress side (egress buffers)
//   conflict/clear_conflict        sticky conflict flag and its clear
//
// Modports:
//   master  the environment: scheduler, ingress and egress agents
//   slave   the crossbar
interface sched_crossbar_reg_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PORT_CNT   = 4
);
  import sched_crossbar_pkg::*;

  localparam int SEL_W = sel_width(PORT_CNT);

  logic [SEL_W*PORT_CNT-1:0]      sched_sel;
  logic [PORT_CNT-1:0]            sched_en;
  logic                           sched_load;
  logic [PORT_CNT-1:0]            in_valid;
  logic [DATA_WIDTH*PORT_CNT-1:0] in_data;
  logic [PORT_CNT-1:0]            in_ready;
  logic [PORT_CNT-1:0]            out_valid;
  logic [DATA_WIDTH*PORT_CNT-1:0] out_data;
  logic [PORT_CNT-1:0]            out_ready;
  logic                           conflict;
  logic                           clear_conflict;

  modport master (
    output sched_sel, sched_en, sched_load, in_valid, in_data, out_ready, clear_conflict,
    input  in_ready, out_valid, out_data, conflict
  );

  modport slave (
    input  sched_sel, sched_en, sched_load, in_valid, in_data, out_ready, clear_conflict,
    output in_ready, out_valid, out_data, conflict
  );

endinterface

// File: rtl/sched_crossbar_reg_xbar_out_reg.sv
// One egress output register with valid/ready handshaking.
//
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   push_valid    the egress owner presents a word this cycle
//   push_data     word from the egress owner
//   slot_free     the register can take a word this cycle (empty, or being drained)
//   out_valid     registered valid
//   out_data      registered data; held stable while out_valid & !out_ready
//   out_ready     downstream accept
module xbar_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  slot_free,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  // A word leaving this cycle frees the slot, so a simultaneous push is allowed.
  // This gives the egress full throughput of one word per cycle.
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (push_valid && slot_free) begin
      out_valid <= 1'b1;
      out_data  <= push_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sched_crossbar_reg.sv
// PORT_CNT x PORT_CNT ingress-to-egress crossbar.
//
// Features:
//   - latched schedule, updated only on sched_load
//   - registered per-egress outputs with valid/ready backpressure
//   - egress conflict resolution: the lowest enabled ingress wins,
//     and a sticky conflict flag records that a clear happened
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   bus         sched_crossbar_reg_if.slave (schedule, ingress, egress, conflict)
//   egress_cnt  only when SCHED_CROSSBAR_STATS_EN is defined: per-egress 32-bit
//               count of output handshakes. Counters wrap and are cleared by
//               clear_conflict.
//
// Optional feature macro: SCHED_CROSSBAR_STATS_EN
module sched_crossbar_reg
  import sched_crossbar_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PORT_CNT   = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  sched_crossbar_reg_if.slave      bus
`ifdef SCHED_CROSSBAR_STATS_EN
  ,
  output logic [32*PORT_CNT-1:0]   egress_cnt
`endif
);

  localparam int SEL_W = sel_width(PORT_CNT);

  logic [PORT_CNT-1:0][SEL_W-1:0]    sched_q_sel;
  logic [PORT_CNT-1:0]               sched_q_en;
  logic [MAX_PORTS-1:0]              wide_en;
  logic [MAX_PORTS-1:0][MAX_SEL_W-1:0] wide_sel;
  resolve_t                          res;
  logic                              unused_res;
  logic [PORT_CNT-1:0]               slot_free;

  // Conflict resolution runs on the incoming schedule, so the latched schedule
  // never holds two enabled ingresses on one egress.
  always_comb begin
    wide_en                 = '0;
    wide_en[PORT_CNT-1:0]   = bus.sched_en;
    wide_sel                = '0;
    for (int i = 0; i < PORT_CNT; i++) begin
      wide_sel[i] = MAX_SEL_W'(bus.sched_sel[i*SEL_W +: SEL_W]);
    end
    res = resolve_conflicts(wide_en, wide_sel, PORT_CNT);
  end

  assign unused_res = ^res.en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sched_q_sel <= '0;
      sched_q_en  <= '0;
    end else if (bus.sched_load) begin
      sched_q_sel <= bus.sched_sel;
      sched_q_en  <= res.en[PORT_CNT-1:0];
    end
  end

  // A conflicting load takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.conflict <= 1'b0;
    end else if (bus.sched_load && res.conflict) begin
      bus.conflict <= 1'b1;
    end else if (bus.clear_conflict) begin
      bus.conflict <= 1'b0;
    end
  end

  genvar gi;

  // Ingress accept. This depends only on the schedule and the egress slot
  // state, never on in_valid.
  generate
    for (gi = 0; gi < PORT_CNT; gi++) begin : g_in_ready
      assign bus.in_ready[gi] = sched_q_en[gi] & slot_free[sched_q_sel[gi]];
    end
  endgenerate

  // Per-egress routing and output register. The latched schedule has at most
  // one owner per egress, so OR-ing the masked ingress words selects that
  // owner's word.
  generate
    for (gi = 0; gi < PORT_CNT; gi++) begin : g_egress
      logic                  push_valid;
      logic [DATA_WIDTH-1:0] push_data;

      always_comb begin
        push_valid = 1'b0;
        push_data  = '0;
        for (int i = 0; i < PORT_CNT; i++) begin
          if (sched_q_en[i] && (sched_q_sel[i] == SEL_W'(gi))) begin
            push_valid = push_valid | bus.in_valid[i];
            push_data  = push_data  | bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end

      xbar_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_valid (push_valid),
        .push_data  (push_data),
        .slot_free  (slot_free[gi]),
        .out_valid  (bus.out_valid[gi]),
        .out_data   (bus.out_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .out_ready  (bus.out_ready[gi])
      );
    end
  endgenerate

`ifdef SCHED_CROSSBAR_STATS_EN
  generate
    for (gi = 0; gi < PORT_CNT; gi++) begin : g_stats
      logic [31:0] cnt_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q <= '0;
        end else if (bus.clear_conflict) begin
          cnt_q <= '0;
        end else if (bus.out_valid[gi] && bus.out_ready[gi]) begin
          cnt_q <= cnt_q + 32'd1;
        end
      end

      assign egress_cnt[gi*32 +: 32] = cnt_q;
    end
  endgenerate
`endif

endmodule

// File: doc/sched_crossbar_reg.md
Name: sched_crossbar_reg

Overview:
- N×N ingress→egress crossbar for the switch fabric.
- Adds three things over a purely combinational crossbar:
  - a latched schedule, updated only on a load strobe;
  - registered per-egress outputs with valid/ready backpressure;
  - detection and resolution of egress conflicts.
- Sits between the ingress VOQ read side and the egress buffers. Driven by the scheduler once per slot.

Parameters:
- DATA_WIDTH, 32, width of one ingress/egress data word.
- PORT_CNT, 4, number of ingress ports; also the number of egress ports; must be ≥2 and a power of two.
- SEL_W, $clog2(PORT_CNT), width of one egress index (derived; not overridden).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sched_sel  in  SEL_W*PORT_CNT  egress index per ingress; ingress i uses slice [i*SEL_W +: SEL_W].
- sched_en  in  PORT_CNT  per-ingress "connection valid" mask, loaded with sched_sel.
- sched_load  in  1  latch sched_sel/sched_en this cycle.
- in_valid  in  PORT_CNT  per-ingress data valid.
- in_data  in  DATA_WIDTH*PORT_CNT  per-ingress data, slice i.
- in_ready  out  PORT_CNT  per-ingress accept.
- out_valid  out  PORT_CNT  per-egress registered valid.
- out_data  out  DATA_WIDTH*PORT_CNT  per-egress registered data, slice e.
- out_ready  in  PORT_CNT  per-egress downstream accept.
- conflict  out  1  sticky: a schedule with two enabled ingresses on one egress was loaded.
- clear_conflict  in  1  synchronous clear of conflict.

Behaviour:
- Reset values (reset_n low, async): sched_q_sel=0, sched_q_en=0, out_valid=0, out_data=0, conflict=0. in_ready=0 follows combinationally because sched_q_en=0.
- Schedule register:
  - On a clk edge with sched_load=1, sched_q_sel/sched_q_en ← inputs.
  - The new schedule governs routing from the next cycle.
  - Data already held in output registers is unaffected by a load.
- Conflict resolution:
  - Evaluated at load time on the incoming schedule.
  - For each egress e, the owner is the lowest-index ingress i with sched_en[i]=1 and sched_sel[i]=e.
  - Any other enabled ingress mapped to e has its en bit cleared before latching.
  - If any clear happens, conflict←1.
  - conflict stays 1 until clear_conflict=1. If clear_conflict and a new conflicting load occur in the same cycle, the set wins.
- Routing, combinational from the latched schedule, per egress e:
  - owner(e) exists ⇒ e's input side = in_valid/in_data of owner.
  - No owner ⇒ nothing is written to e.
- Output stage, one register per egress:
  - slot_free(e) = !out_valid[e] | out_ready[e].
  - in_ready[i] = sched_q_en[i] & slot_free(sched_q_sel[i]).
  - Unscheduled ingresses see in_ready=0.
  - Transfer at ingress i when in_valid[i] & in_ready[i] ⇒ out_data[e] ← in_data[i] and out_valid[e] ← 1, next edge.
  - If out_valid[e] & out_ready[e] and there is no new transfer, out_valid[e] ← 0.
  - Simultaneous pop and push to the same egress ⇒ full throughput, one word/cycle/egress.
- Latency: exactly 1 cycle ingress→egress.
- out_data holds its value while out_valid=1 and out_ready=0 (AXI-style stable).
- in_ready may depend combinationally on out_ready; there is no combinational path from in_valid to in_ready.
- sched_load in the same cycle as a transfer: the transfer uses the old schedule.
- Reset asserted mid-transfer: all held words are dropped; out_valid→0 immediately.

Optional Feature:
- Macro: SCHED_CROSSBAR_STATS_EN.
- Defined:
  - Adds output port egress_cnt (32*PORT_CNT): per-egress 32-bit counters of accepted output handshakes (out_valid & out_ready).
  - Counters wrap modulo 2^32, reset to 0, and are cleared by clear_conflict.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package sched_crossbar_pkg:
  - function clog2-based SEL_W helper;
  - typedef of a per-ingress schedule entry struct {logic en; logic [SEL_W-1:0] sel}, parameterised via localparam default PORT_CNT=4;
  - function resolve_conflicts returning the cleaned en mask plus a conflict bit.
- Sub-module xbar_out_reg: one per egress via generate. Contains the valid/ready pipeline register (slot_free, out_valid, out_data).

Test Plan:
- Identity schedule (ingress i→egress i, all en), all valid, out_ready=all 1, in_data[i]=0xA0+i ⇒ next cycle out_data[e]=0xA0+e, out_valid=4'b1111, steady one word/cycle.
- Permutation sel={0,1,2,3} for ingress {3,2,1,0}, ingress0 sends 0x11 ⇒ egress3 outputs 0x11 after 1 cycle; other egresses valid only for their own owners.
- Conflict: ingress0 and ingress2 both →egress1, en=4'b0101 ⇒ conflict=1 after load; only ingress0 in_ready=1; ingress2 in_ready=0; clear_conflict ⇒ conflict=0.
- Backpressure: egress2 out_ready=0 with a held word 0x55 ⇒ out_data[2] stays 0x55; the mapped ingress's in_ready=0; release out_ready ⇒ next queued word appears the following cycle, no loss or duplication.
- sched_load coincident with transfer: old map ingress1→egress0, new map ingress1→egress3 ⇒ that word lands on egress0; the next word lands on egress3.
- Async reset asserted mid-stream with out_valid=4'b1111 ⇒ out_valid=0, conflict=0, in_ready=0 without a clock edge. With SCHED_CROSSBAR_STATS_EN, 5 handshakes on egress0 ⇒ egress_cnt[0]=5.
